// File: rtl/cpu_ctrl_pkg.sv
// EX-stage control encodings shared by the ALU, the result mux and the HI/LO writer.
package cpu_ctrl_pkg;

   localparam logic [3:0] SIG_AND   = 4'b0000;
   localparam logic [3:0] SIG_OR    = 4'b0001;
   localparam logic [3:0] SIG_ADD   = 4'b0010;
   localparam logic [3:0] SIG_SRL   = 4'b0011;
   localparam logic [3:0] SIG_SUB   = 4'b0110;
   localparam logic [3:0] SIG_SLT   = 4'b0111;
   localparam logic [3:0] SIG_MFLO  = 4'b1000;
   localparam logic [3:0] SIG_MFHI  = 4'b1001;
   localparam logic [3:0] SIG_MULTU = 4'b1010;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } mult_state_e;

endpackage

// File: rtl/multu_hilo_hilo_reg.sv
// Architectural HI/LO register pair; loads both halves together on a write strobe.
module hilo_reg #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we_i,
   input  logic [WIDTH-1:0] hi_i,
   input  logic [WIDTH-1:0] lo_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;

   // Both halves always move together so HI/LO is never seen half-written.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hi_q <= {WIDTH{1'b0}};
         lo_q <= {WIDTH{1'b0}};
      end else if (we_i) begin
         hi_q <= hi_i;
         lo_q <= lo_i;
      end else begin
         hi_q <= hi_q;
         lo_q <= lo_q;
      end
   end

   assign hi_o = hi_q;
   assign lo_o = lo_q;

endmodule

// File: rtl/multu_hilo.sv
// Iterative 32-step shift-add MULTU unit writing the HI/LO pair, with a stall
// request that holds HI/LO readers and a new MULTU while a multiply is in flight.
module multu_hilo
   import cpu_ctrl_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [3:0]       Signal,
   input  logic [WIDTH-1:0] dataA,
   input  logic [WIDTH-1:0] dataB,
   output logic [WIDTH-1:0] HiOut,
   output logic [WIDTH-1:0] LoOut,
   output logic             busy,
   output logic             done,
   output logic             stall
);

   mult_state_e        state_q;
   logic [WIDTH-1:0]   mcand_q;
   logic [2*WIDTH-1:0] prod_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               busy_q;
   logic               done_q;

   logic [WIDTH:0]     sum_d;
   logic [2*WIDTH-1:0] prod_d;
   logic               accept_d;
   logic               last_d;
   logic               hilo_op_d;

   // One shift-add step; the extra sum bit keeps the carry out of the upper half.
   always_comb begin
      sum_d     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                  (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
      prod_d    = {sum_d, prod_q[WIDTH-1:1]};
      accept_d  = (state_q == IDLE) && en && (Signal == SIG_MULTU);
      last_d    = (state_q == RUN) && (cnt_q == CNT_W'(WIDTH-1));
      case (Signal)
         SIG_MFHI, SIG_MFLO, SIG_MULTU: hilo_op_d = 1'b1;
         default:                       hilo_op_d = 1'b0;
      endcase
   end

   // Control FSM and multiplier datapath registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         mcand_q <= {WIDTH{1'b0}};
         prod_q  <= {(2*WIDTH){1'b0}};
         cnt_q   <= {CNT_W{1'b0}};
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= last_d;
         case (state_q)
            IDLE: begin
               if (accept_d) begin
                  mcand_q <= dataA;
                  prod_q  <= {{WIDTH{1'b0}}, dataB};
                  cnt_q   <= {CNT_W{1'b0}};
                  state_q <= RUN;
                  busy_q  <= 1'b1;
               end else begin
                  busy_q  <= 1'b0;
               end
            end
            RUN: begin
               prod_q <= prod_d;
               cnt_q  <= cnt_q + CNT_W'(1);
               if (last_d) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  busy_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // The final step's product goes straight into HI/LO, not via prod_q.
   hilo_reg #(.WIDTH(WIDTH)) u_hilo (
      .clk   (clk),
      .rst_n (rst_n),
      .we_i  (last_d),
      .hi_i  (prod_d[2*WIDTH-1:WIDTH]),
      .lo_i  (prod_d[WIDTH-1:0]),
      .hi_o  (HiOut),
      .lo_o  (LoOut)
   );

   assign busy  = busy_q;
   assign done  = done_q;
   assign stall = en && busy_q && hilo_op_d;

endmodule

// File: tb/tb_multu_hilo.sv
// Randomized self-checking bench for multu_hilo against a plain 64-bit product model.
module tb_multu_hilo;

   localparam logic [3:0] C_ADD   = 4'b0010;
   localparam logic [3:0] C_MFHI  = 4'b1001;
   localparam logic [3:0] C_MULTU = 4'b1010;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [3:0]  Signal;
   logic [31:0] dataA;
   logic [31:0] dataB;
   logic [31:0] HiOut;
   logic [31:0] LoOut;
   logic        busy;
   logic        done;
   logic        stall;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] mdl_hi;
   logic [31:0] mdl_lo;

   multu_hilo #(.WIDTH(32), .CNT_W(6)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .Signal (Signal),
      .dataA  (dataA),
      .dataB  (dataB),
      .HiOut  (HiOut),
      .LoOut  (LoOut),
      .busy   (busy),
      .done   (done),
      .stall  (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Run out a multiply from the cycle after accept; 32 edges to HI/LO valid.
   task automatic finish_run(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      p = 64'(a) * 64'(b);
      for (int i = 1; i <= 32; i++) begin
         step();
         if (i < 32) begin
            check_eq("busy_run", {63'd0, busy}, 64'd1);
            check_eq("done_run", {63'd0, done}, 64'd0);
            check_eq("hilo_hold", {HiOut, LoOut}, {mdl_hi, mdl_lo});
         end else begin
            check_eq("busy_end", {63'd0, busy}, 64'd0);
            check_eq("done_pulse", {63'd0, done}, 64'd1);
            check_eq("hi_result", {32'd0, HiOut}, {32'd0, p[63:32]});
            check_eq("lo_result", {32'd0, LoOut}, {32'd0, p[31:0]});
         end
      end
      mdl_hi = p[63:32];
      mdl_lo = p[31:0];
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b);
      en = 1'b1; Signal = C_MULTU; dataA = a; dataB = b;
      #1;
      check_eq("stall_accept", {63'd0, stall}, 64'd0);
      step();
      en = 1'b0; Signal = C_ADD; dataA = $urandom; dataB = $urandom;
      check_eq("busy_accept", {63'd0, busy}, 64'd1);
   endtask

   task automatic do_mult(input logic [31:0] a, input logic [31:0] b);
      issue(a, b);
      finish_run(a, b);
      step();
      check_eq("done_once", {63'd0, done}, 64'd0);
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; Signal = C_ADD; dataA = 32'd0; dataB = 32'd0;
      mdl_hi = 32'd0; mdl_lo = 32'd0;
      step(); step();
      check_eq("rst_hilo", {HiOut, LoOut}, 64'd0);
      check_eq("rst_busy", {62'd0, busy, done}, 64'd0);
      rst_n = 1'b1;
      step();

      do_mult(32'd3, 32'd5);
      do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      for (int k = 0; k < 6; k++) do_mult($urandom, $urandom);

      // MFHI stalls through the run and sees the new HI once released; ADD never stalls.
      issue(32'h1234_5678, 32'h9ABC_DEF0);
      en = 1'b1; Signal = C_ADD; #1;
      check_eq("stall_add", {63'd0, stall}, 64'd0);
      step();
      Signal = C_MFHI;
      for (int i = 2; i <= 32; i++) begin
         #1;
         check_eq("stall_mfhi", {63'd0, stall}, 64'd1);
         step();
      end
      mdl_hi = 32'(({32'd0, 32'h1234_5678} * {32'd0, 32'h9ABC_DEF0}) >> 32);
      mdl_lo = 32'h1234_5678 * 32'h9ABC_DEF0;
      check_eq("stall_release", {63'd0, stall}, 64'd0);
      check_eq("mfhi_new", {32'd0, HiOut}, {32'd0, mdl_hi});
      en = 1'b0; Signal = C_ADD;
      step();

      // Reset in the middle of a run aborts it without any HI/LO write.
      do_mult(32'h8000_0001, 32'd2);
      check_eq("pre_rst_hilo", {HiOut, LoOut}, 64'h0000_0001_0000_0002);
      issue($urandom, $urandom);
      for (int i = 0; i < 10; i++) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      mdl_hi = 32'd0; mdl_lo = 32'd0;
      check_eq("midrst_hilo", {HiOut, LoOut}, 64'd0);
      check_eq("midrst_flags", {62'd0, busy, done}, 64'd0);
      do_mult(32'd7, 32'd6);
      check_eq("lo_2a", {32'd0, LoOut}, 64'h2A);

      // Back-to-back: the second MULTU waits on stall, then issues the cycle it drops.
      issue(32'h0001_0000, 32'h0001_0000);
      en = 1'b1; Signal = C_MULTU; dataA = 32'd0; dataB = 32'h1234;
      for (int i = 1; i <= 32; i++) begin
         #1;
         check_eq("stall_b2b", {63'd0, stall}, 64'd1);
         step();
      end
      check_eq("b2b_release", {62'd0, stall, busy}, 64'd0);
      check_eq("b2b_first", {HiOut, LoOut}, 64'h0000_0001_0000_0000);
      mdl_hi = 32'd1; mdl_lo = 32'd0;
      step();
      en = 1'b0; Signal = C_ADD;
      check_eq("b2b_accept", {63'd0, busy}, 64'd1);
      finish_run(32'd0, 32'h1234);

      // en low blocks the accept.
      step();
      en = 1'b0; Signal = C_MULTU; dataA = 32'd9; dataB = 32'd9;
      for (int i = 0; i < 4; i++) begin
         step();
         check_eq("en0_busy", {63'd0, busy}, 64'd0);
         check_eq("en0_stall", {63'd0, stall}, 64'd0);
      end
      check_eq("en0_hilo", {HiOut, LoOut}, {mdl_hi, mdl_lo});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/multu_hilo.md
Name: multu_hilo

Overview:
- Writer side of the HI/LO register pair that the EX-stage result mux reads through its MFHI/MFLO selects.
- Sits beside the ALU in EX and executes MULTU as an iterative 32-cycle shift-add unsigned multiplier.
- On completion it updates the architectural HI/LO registers.
- Drives a stall request so the pipeline does not read HI/LO, or issue a new MULTU, while a multiply is in flight.

Parameters:
- WIDTH, 32: operand width; product is 2*WIDTH bits.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- en  input  1  EX stage holds a valid instruction this cycle.
- Signal  input  4  ALU control code from the EX stage; same encoding as the ALU and result mux.
- dataA  input  WIDTH  rs operand (multiplicand).
- dataB  input  WIDTH  rt operand (multiplier).
- HiOut  output  WIDTH  architectural HI register.
- LoOut  output  WIDTH  architectural LO register.
- busy  output  1  multiply in flight.
- done  output  1  one-cycle pulse: HI/LO were written at the preceding edge.
- stall  output  1  combinational stall request to the hazard unit.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; HiOut=0, LoOut=0; busy=0, done=0.
  - Counter and working product register cleared.
  - A multiply in progress is aborted with no HI/LO write.
- States:
  - IDLE: wait for a MULTU.
  - RUN: iterating.
- Accept: at an edge where state=IDLE, en=1 and Signal=MULTU (4'b1010):
  - Latch mcand=dataA; prod={WIDTH'b0, dataB}; cnt=0.
  - state goes to RUN; busy=1 from that edge.
  - stall=0 in the accepting cycle, so the MULTU retires normally (non-blocking issue).
- RUN, every edge:
  - sum = {1'b0, prod[2W-1:W]} + (prod[0] ? {1'b0, mcand} : 0), computed as a WIDTH+1-bit add.
  - prod = {sum, prod[W-1:1]}; cnt = cnt + 1.
- Completion, at the edge where cnt=WIDTH-1 (the 32nd RUN edge):
  - The iteration result is written directly: HiOut = new prod[2W-1:W], LoOut = new prod[W-1:0].
  - state goes to IDLE; busy=0; done=1 for exactly the following cycle.
  - Latency: accept edge + 32 edges to HI/LO valid.
- HiOut/LoOut change only at completion or reset. They hold old values during RUN and are never partially updated.
- stall = en & busy & (Signal==MFHI (4'b1001) | Signal==MFLO (4'b1000) | Signal==MULTU).
  - Purely combinational; drops in the cycle after the completion edge, when busy=0.
  - The stalled MFHI/MFLO then sees the new values.
  - A stalled MULTU is accepted in that same cycle (back-to-back issue, one idle cycle between runs).
- Other Signal codes (AND/OR/ADD/SUB/SLT/SRL) are ignored in all states and never stall.
- en=0: no accept, stall=0. RUN continues regardless of en.
- Operand changes during RUN have no effect; operands are latched at accept.
- No divide/MTHI/MTLO support; unknown codes are ignored.

Decomposition:
- Shared package/header cpu_ctrl_pkg:
  - Signal encodings: AND 0000, OR 0001, ADD 0010, SRL 0011, SUB 0110, SLT 0111, MFLO 1000, MFHI 1001, MULTU 1010.
  - State encoding IDLE/RUN.
- These encodings are the single source shared with the ALU and the EX result mux.
- One natural sub-module: hilo_reg (the WIDTH-bit HI/LO register pair with synchronous active-low clear and a write strobe). Multiplier datapath and FSM stay in multu_hilo.

Test Plan:
- Reset, then MULTU dataA=3, dataB=5 -> busy high for 32 cycles; HI=0x00000000, LO=0x0000000F; done pulses once; no earlier HI/LO change.
- MULTU 0xFFFFFFFF * 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 (carry-out of the WIDTH+1 add exercised).
- MFHI presented with en=1 two cycles after accept -> stall=1 until busy drops; first non-stalled cycle shows the new HiOut; an ADD presented during RUN -> stall=0.
- rst_n=0 at RUN cycle 10 after a prior result HI=0x1, LO=0x2 -> next cycle HI=0, LO=0, busy=0, done=0; a later MULTU 7*6 gives LO=0x2A.
- MULTU 0x10000 * 0x10000, then a second MULTU 0*0x1234 held during stall -> first gives HI=0x1, LO=0; second is accepted the cycle stall drops and gives HI=0, LO=0.
- en=0 with Signal=MULTU -> no accept, busy stays 0, HI/LO unchanged.
